// File: rtl/scroll_selector_if.sv
// ---------------------------------------------------------------------------
// scroll_selector_if
// Groups the button inputs and the position outputs of scroll_selector.
//   in_left, in_right : button levels, already synchronized to clk
//   pos               : current position index (PW bits)
//   sel_onehot        : one-hot decode of pos (N_POS bits)
//   at_min, at_max    : pos is at the lower / upper end
//   moved             : one-cycle pulse after pos changed
// The slave modport belongs to the tracker and the master modport to whoever
// drives the buttons and consumes the position.
// ---------------------------------------------------------------------------
interface scroll_selector_if #(
  parameter int N_POS = 4,
  parameter int PW    = (N_POS > 1) ? $clog2(N_POS) : 1
);
  logic             in_left;
  logic             in_right;
  logic [PW-1:0]    pos;
  logic [N_POS-1:0] sel_onehot;
  logic             at_min;
  logic             at_max;
  logic             moved;

  modport master (
    output in_left, in_right,
    input  pos, sel_onehot, at_min, at_max, moved
  );

  modport slave (
    input  in_left, in_right,
    output pos, sel_onehot, at_min, at_max, moved
  );
endinterface

// File: rtl/scroll_selector.sv
// ---------------------------------------------------------------------------
// scroll_selector
// Turns two level-sensitive direction buttons into a bounded position index.
// One step per press, optional hold-to-auto-repeat, saturating or wrapping
// at the ends.
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : scroll_selector_if.slave (buttons in, pos/sel_onehot/at_min/
//            at_max/moved out; all outputs registered)
// ---------------------------------------------------------------------------
module scroll_selector #(
  parameter int N_POS        = 4,
  parameter int WRAP         = 0,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 1
) (
  input  logic               clk,
  input  logic               reset,
  scroll_selector_if.slave   bus
);

  localparam int PW   = $clog2(N_POS);
  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0]    POS_MAX  = PW'(N_POS - 1);
  localparam logic [N_POS-1:0] ONE_HOT0 = N_POS'(1);
  // With auto-repeat disabled the delay compare is never used.
  localparam logic [CW-1:0]    DLY_END  = (REPEAT_DELAY > 0) ? CW'(REPEAT_DELAY - 1) : CW'(0);
  localparam logic [CW-1:0]    RATE_END = CW'(REPEAT_RATE - 1);
  localparam bit               HAS_REPEAT = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  state_e           r_state;
  dir_e             r_dir_q;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_pos;
  logic [N_POS-1:0] r_sel;
  logic             r_at_min;
  logic             r_at_max;
  logic             r_moved;

  dir_e             w_dir;
  logic             w_fresh;
  logic             w_step;
  state_e           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [PW-1:0]    w_pos_nxt;

  // Explicit end compare keeps a non-power-of-2 N_POS inside 0..N_POS-1.
  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input dir_e d);
    logic [PW-1:0] res;
    res = p;
    case (d)
      DIR_RIGHT: begin
        if (p == POS_MAX) begin
          res = (WRAP != 0) ? PW'(0) : p;
        end else begin
          res = p + PW'(1);
        end
      end
      DIR_LEFT: begin
        if (p == PW'(0)) begin
          res = (WRAP != 0) ? POS_MAX : p;
        end else begin
          res = p - PW'(1);
        end
      end
      default: res = p;
    endcase
    return res;
  endfunction

  // Direction sampled this edge; both or neither pressed counts as none.
  always_comb begin
    w_dir = DIR_NONE;
    if (bus.in_right && !bus.in_left) begin
      w_dir = DIR_RIGHT;
    end else if (bus.in_left && !bus.in_right) begin
      w_dir = DIR_LEFT;
    end else begin
      w_dir = DIR_NONE;
    end
  end

  // Fresh press or direct reversal relative to last edge's direction.
  assign w_fresh = (w_dir != DIR_NONE) && (w_dir != r_dir_q);

  // Next-state, counter and step decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fresh) begin
          w_step      = 1'b1;
          w_cnt_nxt   = CW'(0);
          w_state_nxt = ST_FIRST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FIRST: begin
        if (w_dir == DIR_NONE) begin
          w_cnt_nxt   = CW'(0);
          w_state_nxt = ST_IDLE;
        end else if (w_fresh) begin
          w_step      = 1'b1;
          w_cnt_nxt   = CW'(0);
          w_state_nxt = ST_FIRST;
        end else if (HAS_REPEAT && (r_cnt == DLY_END)) begin
          w_step      = 1'b1;
          w_cnt_nxt   = CW'(0);
          w_state_nxt = ST_REPEAT;
        end else if (HAS_REPEAT) begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end else begin
          // No auto-repeat: park here until the direction changes.
          w_cnt_nxt   = r_cnt;
        end
      end
      ST_REPEAT: begin
        if (w_dir == DIR_NONE) begin
          w_cnt_nxt   = CW'(0);
          w_state_nxt = ST_IDLE;
        end else if (w_fresh) begin
          w_step      = 1'b1;
          w_cnt_nxt   = CW'(0);
          w_state_nxt = ST_FIRST;
        end else if (r_cnt == RATE_END) begin
          w_step      = 1'b1;
          w_cnt_nxt   = CW'(0);
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_cnt_nxt   = CW'(0);
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_pos_nxt = w_step ? step_pos(r_pos, w_dir) : r_pos;

  // State, direction history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_dir_q  <= DIR_NONE;
      r_cnt    <= CW'(0);
      r_pos    <= PW'(0);
      r_sel    <= ONE_HOT0;
      r_at_min <= 1'b1;
      r_at_max <= 1'b0;
      r_moved  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir_q  <= w_dir;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_pos_nxt;
      r_sel    <= ONE_HOT0 << w_pos_nxt;
      r_at_min <= (w_pos_nxt == PW'(0));
      r_at_max <= (w_pos_nxt == POS_MAX);
      r_moved  <= (w_pos_nxt != r_pos);
    end
  end

  assign bus.pos        = r_pos;
  assign bus.sel_onehot = r_sel;
  assign bus.at_min     = r_at_min;
  assign bus.at_max     = r_at_max;
  assign bus.moved      = r_moved;

endmodule

// File: tb/tb_scroll_selector.sv
// ---------------------------------------------------------------------------
// tb_scroll_selector
// Three scroll_selector instances:
//   inst 0 : N_POS=5, saturating, no repeat
//   inst 1 : N_POS=5, wrapping,   no repeat
//   inst 2 : N_POS=8, saturating, REPEAT_DELAY=4, REPEAT_RATE=2
// Each directed step pushes the expected position/moved onto a queue, drives
// one clock edge, then pops and compares all outputs of the targeted instance.
// ---------------------------------------------------------------------------
module tb_scroll_selector;

  logic clk;
  logic reset;

  scroll_selector_if #(.N_POS(5)) if0 ();
  scroll_selector_if #(.N_POS(5)) if1 ();
  scroll_selector_if #(.N_POS(8)) if2 ();

  scroll_selector #(.N_POS(5), .WRAP(0), .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_sat (
    .clk(clk), .reset(reset), .bus(if0)
  );
  scroll_selector #(.N_POS(5), .WRAP(1), .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_wrap (
    .clk(clk), .reset(reset), .bus(if1)
  );
  scroll_selector #(.N_POS(8), .WRAP(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)) u_rep (
    .clk(clk), .reset(reset), .bus(if2)
  );

  typedef struct {
    string tag;
    int    pos;
    bit    moved;
    int    n;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
  endtask

  task automatic compare(input logic [31:0] o_pos, input logic o_mv, input logic o_min,
                         input logic o_max, input logic [31:0] o_sel);
    exp_t e;
    logic [31:0] one;
    e   = exp_q.pop_front();
    one = 32'd1;
    chk(e.tag, "pos",    o_pos, 32'(e.pos));
    chk(e.tag, "moved",  {31'd0, o_mv}, {31'd0, e.moved});
    chk(e.tag, "at_min", {31'd0, o_min}, (e.pos == 0) ? 32'd1 : 32'd0);
    chk(e.tag, "at_max", {31'd0, o_max}, (e.pos == e.n - 1) ? 32'd1 : 32'd0);
    chk(e.tag, "sel",    o_sel, one << e.pos);
  endtask

  task automatic step(input int inst, input bit rst, input bit l, input bit r,
                      input string tag, input int epos, input bit emov);
    exp_t e;
    e.tag = tag; e.pos = epos; e.moved = emov; e.n = (inst == 2) ? 8 : 5;
    exp_q.push_back(e);
    reset = rst;
    case (inst)
      0:       begin if0.in_left = l; if0.in_right = r; end
      1:       begin if1.in_left = l; if1.in_right = r; end
      default: begin if2.in_left = l; if2.in_right = r; end
    endcase
    @(posedge clk);
    #1;
    case (inst)
      0:       compare(32'(if0.pos), if0.moved, if0.at_min, if0.at_max, 32'(if0.sel_onehot));
      1:       compare(32'(if1.pos), if1.moved, if1.at_min, if1.at_max, 32'(if1.sel_onehot));
      default: compare(32'(if2.pos), if2.moved, if2.at_min, if2.at_max, 32'(if2.sel_onehot));
    endcase
  endtask

  // One-edge press followed by one-edge release.
  task automatic press(input int inst, input bit l, input bit r, input string tag,
                       input int epos, input bit emov);
    step(inst, 1'b0, l, r, tag, epos, emov);
    step(inst, 1'b0, 1'b0, 1'b0, {tag, "_rel"}, epos, 1'b0);
  endtask

  initial begin
    int sat_r[5];
    int sat_l[6];
    int hold_p[10];
    sat_r  = '{1, 2, 3, 4, 4};
    sat_l  = '{3, 2, 1, 0, 0, 0};
    hold_p = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

    reset = 1'b1;
    if0.in_left = 1'b0; if0.in_right = 1'b0;
    if1.in_left = 1'b0; if1.in_right = 1'b0;
    if2.in_left = 1'b0; if2.in_right = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 1'b1, 1'b0, 1'b0, "rst_i0", 0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, "rst_i1", 0, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0, "rst_i2", 0, 1'b0);

    // Saturating: five right presses, then six left presses.
    for (int i = 0; i < 5; i++)
      press(0, 1'b0, 1'b1, $sformatf("sat_r%0d", i), sat_r[i], (i < 4));
    for (int i = 0; i < 6; i++)
      press(0, 1'b1, 1'b0, $sformatf("sat_l%0d", i), sat_l[i], (i < 4));

    // Wrapping: walk to the top, then wrap both ways.
    for (int i = 1; i <= 4; i++)
      press(1, 1'b0, 1'b1, $sformatf("wrap_up%0d", i), i, 1'b1);
    press(1, 1'b0, 1'b1, "wrap_r", 0, 1'b1);
    press(1, 1'b1, 1'b0, "wrap_l", 4, 1'b1);

    // Auto-repeat: hold right for 10 edges, steps at k, k+4, k+6, k+8.
    for (int j = 0; j < 10; j++)
      step(2, 1'b0, 1'b0, 1'b1, $sformatf("hold%0d", j), hold_p[j],
           (j == 0) || (j == 4) || (j == 6) || (j == 8));
    for (int j = 0; j < 2; j++)
      step(2, 1'b0, 1'b0, 1'b0, $sformatf("hold_rel%0d", j), 4, 1'b0);

    // Both held counts as none; releasing right leaves a fresh left press.
    step(2, 1'b0, 1'b0, 1'b1, "bh_r", 5, 1'b1);
    for (int j = 0; j < 3; j++)
      step(2, 1'b0, 1'b1, 1'b1, $sformatf("bh_both%0d", j), 5, 1'b0);
    step(2, 1'b0, 1'b1, 1'b0, "bh_relr", 4, 1'b1);
    step(2, 1'b0, 1'b0, 1'b0, "bh_rel", 4, 1'b0);

    // Reversal from 2: right to 3, then left immediately back to 2 with the
    // delay timer restarted (next repeat four edges later).
    press(2, 1'b1, 1'b0, "rv_p0", 3, 1'b1);
    press(2, 1'b1, 1'b0, "rv_p1", 2, 1'b1);
    step(2, 1'b0, 1'b0, 1'b1, "rev_r", 3, 1'b1);
    step(2, 1'b0, 1'b1, 1'b0, "rev_l", 2, 1'b1);
    for (int j = 0; j < 3; j++)
      step(2, 1'b0, 1'b1, 1'b0, $sformatf("rev_wait%0d", j), 2, 1'b0);
    step(2, 1'b0, 1'b1, 1'b0, "rev_rep", 1, 1'b1);
    step(2, 1'b0, 1'b0, 1'b0, "rev_rel", 1, 1'b0);

    // Reset mid-hold at 3; right still held afterwards gives a fresh step.
    press(2, 1'b0, 1'b1, "mh_p", 2, 1'b1);
    step(2, 1'b0, 1'b0, 1'b1, "mh_r", 3, 1'b1);
    step(2, 1'b1, 1'b0, 1'b1, "mh_rst", 0, 1'b0);
    step(2, 1'b0, 1'b0, 1'b1, "mh_post", 1, 1'b1);
    step(2, 1'b0, 1'b0, 1'b0, "mh_rel", 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
